exe_issue_arbiter: RTL and testbench

//  Picks one ready reservation-station entry per cycle and issues it into the single EXE unit.

---
 rtl/exe_issue_arbiter.sv | 129 ++++++++++++
 tb/tb_exe_issue_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue_arbiter.sv
// Oldest-first issue arbiter feeding the single EXE unit. It holds off all issue
// while a multi-cycle mult/div occupies EXE, and masks the entry it just granted.
module exe_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int AGE_W      = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         flush_IN,
    input  logic                         IF_stall_request,
    input  logic [NUM_REQ-1:0]           req_valid_IN,
    input  logic [NUM_REQ-1:0]           req_muldiv_IN,
    input  logic [NUM_REQ*AGE_W-1:0]     req_age_IN,
    output logic                         issue_valid_OUT,
    output logic [NUM_REQ-1:0]           issue_grant_OUT,
    output logic [$clog2(NUM_REQ)-1:0]   issue_idx_OUT,
    output logic [AGE_W-1:0]             issue_age_OUT,
    output logic                         exe_busy_OUT
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MULDIV_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [AGE_W-1:0]     age_q, age_d;

    logic [AGE_W-1:0]     age [NUM_REQ];
    logic [NUM_REQ-1:0]   eligible;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
        assign age[g] = req_age_IN[g*AGE_W +: AGE_W];
    end

    assign eligible = req_valid_IN & ~mask_q;

    // Ages wrap, so "older" is the sign of the modular difference.
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i] && (!sel_found || older(age[i], age[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        grant_d = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        age_d   = '0;
        if (flush_IN) begin
            state_d = IDLE;
            cnt_d   = '0;
            mask_d  = '0;
        end else if (!IF_stall_request) begin
            // A stall keeps state, count and mask; only the grant drops.
            unique case (state_q)
                IDLE: begin
                    mask_d = '0;
                    if (sel_found) begin
                        grant_d[sel_idx] = 1'b1;
                        valid_d          = 1'b1;
                        idx_d            = sel_idx;
                        age_d            = age[sel_idx];
                        mask_d[sel_idx]  = 1'b1;
                        if (req_muldiv_IN[sel_idx]) begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(MULDIV_LAT - 1);
                        end
                    end
                end
                BUSY: begin
                    mask_d = '0;
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            age_q   <= age_d;
        end
    end

    assign issue_valid_OUT = valid_q;
    assign issue_grant_OUT = grant_q;
    assign issue_idx_OUT   = idx_q;
    assign issue_age_OUT   = age_q;
    assign exe_busy_OUT    = (state_q == BUSY);

endmodule

// File: tb/tb_exe_issue_arbiter.sv
// Bench for exe_issue_arbiter: directed vector table, hand-built corner sequences,
// then random traffic checked against an offset-based oldest-first model.
module tb_exe_issue_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AGE_W   = 32;
    localparam int LAT     = 4;

    logic                       CLK = 1'b0;
    logic                       RESET;
    logic                       flush_IN;
    logic                       IF_stall_request;
    logic [NUM_REQ-1:0]         req_valid_IN;
    logic [NUM_REQ-1:0]         req_muldiv_IN;
    logic [NUM_REQ*AGE_W-1:0]   req_age_IN;
    logic                       issue_valid_OUT;
    logic [NUM_REQ-1:0]         issue_grant_OUT;
    logic [1:0]                 issue_idx_OUT;
    logic [AGE_W-1:0]           issue_age_OUT;
    logic                       exe_busy_OUT;

    int n_cmp = 0;
    int n_err = 0;

    exe_issue_arbiter #(.NUM_REQ(NUM_REQ), .AGE_W(AGE_W), .MULDIV_LAT(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .flush_IN(flush_IN), .IF_stall_request(IF_stall_request),
        .req_valid_IN(req_valid_IN), .req_muldiv_IN(req_muldiv_IN), .req_age_IN(req_age_IN),
        .issue_valid_OUT(issue_valid_OUT), .issue_grant_OUT(issue_grant_OUT),
        .issue_idx_OUT(issue_idx_OUT), .issue_age_OUT(issue_age_OUT), .exe_busy_OUT(exe_busy_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0]       md;
        logic [3:0][31:0] a;
        logic             ev;
        logic [1:0]       ei;
        logic [31:0]      ea;
        logic             eb;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] md,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic ev, input logic [1:0] ei,
                                input logic [31:0] ea, input logic eb);
        vec_t t;
        t.v = v; t.md = md; t.a = {a3, a2, a1, a0};
        t.ev = ev; t.ei = ei; t.ea = ea; t.eb = eb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input int idx,
                           input logic [31:0] age, input logic busy);
        logic [3:0] g;
        g = v ? (4'b0001 << idx) : 4'b0000;
        chk({nm, ".valid"}, issue_valid_OUT, v);
        chk({nm, ".grant"}, issue_grant_OUT, g);
        chk({nm, ".idx"},   issue_idx_OUT,   v ? idx : 0);
        chk({nm, ".age"},   issue_age_OUT,   v ? age : 32'd0);
        chk({nm, ".busy"},  exe_busy_OUT,    busy);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] md,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3);
        req_valid_IN  = v;
        req_muldiv_IN = md;
        req_age_IN    = {a3, a2, a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        int   rem;
        logic [3:0] mmask;

        RESET = 1'b1; flush_IN = 1'b0; IF_stall_request = 1'b0;
        drive(4'b0, 4'b0, 0, 0, 0, 0);
        #1;
        chk_out("reset", 1'b0, 0, 0, 1'b0);
        tick(); tick();
        #3 RESET = 1'b0;
        chk_out("reset_rel", 1'b0, 0, 0, 1'b0);

        tbl[0]  = mk(4'b1111, 4'b0000, 10, 5, 7, 9, 1, 1, 5, 0);
        tbl[1]  = mk(4'b1101, 4'b0000, 10, 5, 7, 9, 1, 2, 7, 0);
        tbl[2]  = mk(4'b1001, 4'b0000, 10, 5, 7, 9, 1, 3, 9, 0);
        tbl[3]  = mk(4'b0001, 4'b0000, 10, 5, 7, 9, 1, 0, 10, 0);
        tbl[4]  = mk(4'b0000, 4'b0000, 10, 5, 7, 9, 0, 0, 0, 0);
        tbl[5]  = mk(4'b0011, 4'b0000, 3, 3, 8, 9, 1, 0, 3, 0);
        tbl[6]  = mk(4'b0011, 4'b0000, 3, 3, 8, 9, 1, 1, 3, 0);
        tbl[7]  = mk(4'b0000, 4'b0000, 3, 3, 8, 9, 0, 0, 0, 0);
        tbl[8]  = mk(4'b0011, 4'b0000, 32'hFFFF_FFFE, 2, 0, 0, 1, 0, 32'hFFFF_FFFE, 0);
        tbl[9]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(4'b1100, 4'b0100, 0, 0, 1, 50, 1, 2, 1, 1);
        tbl[11] = mk(4'b1000, 4'b0000, 0, 0, 1, 50, 0, 0, 0, 1);
        tbl[12] = mk(4'b1000, 4'b0000, 0, 0, 1, 50, 0, 0, 0, 1);
        tbl[13] = mk(4'b1000, 4'b0000, 0, 0, 1, 50, 0, 0, 0, 0);
        tbl[14] = mk(4'b1000, 4'b0000, 0, 0, 1, 50, 1, 3, 50, 0);
        tbl[15] = mk(4'b0000, 4'b0000, 0, 0, 1, 50, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            req_valid_IN  = tbl[i].v;
            req_muldiv_IN = tbl[i].md;
            req_age_IN    = tbl[i].a;
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].ev, int'(tbl[i].ei), tbl[i].ea, tbl[i].eb);
        end

        // Stall inside BUSY stretches occupancy by the stalled cycles.
        drive(4'b1100, 4'b0100, 0, 0, 1, 50); tick(); chk_out("stb.grant", 1, 2, 1, 1);
        drive(4'b1000, 4'b0000, 0, 0, 1, 50); tick(); chk_out("stb.b1", 0, 0, 0, 1);
        IF_stall_request = 1'b1;              tick(); chk_out("stb.s1", 0, 0, 0, 1);
                                              tick(); chk_out("stb.s2", 0, 0, 0, 1);
        IF_stall_request = 1'b0;              tick(); chk_out("stb.b2", 0, 0, 0, 1);
                                              tick(); chk_out("stb.idle", 0, 0, 0, 0);
                                              tick(); chk_out("stb.alu", 1, 3, 50, 0);
        drive(4'b0000, 4'b0000, 0, 0, 0, 0); tick(); chk_out("stb.end", 0, 0, 0, 0);

        // Mask survives a stall: the just-granted entry is not reissued.
        drive(4'b0011, 4'b0000, 1, 2, 0, 0); tick(); chk_out("msk.g0", 1, 0, 1, 0);
        IF_stall_request = 1'b1;              tick(); chk_out("msk.st", 0, 0, 0, 0);
        IF_stall_request = 1'b0;              tick(); chk_out("msk.g1", 1, 1, 2, 0);
        drive(4'b0000, 4'b0000, 0, 0, 0, 0); tick(); chk_out("msk.end", 0, 0, 0, 0);

        // Flush beats stall and cancels BUSY.
        drive(4'b0001, 4'b0001, 5, 0, 0, 0); tick(); chk_out("fl.grant", 1, 0, 5, 1);
        drive(4'b0000, 4'b0000, 5, 0, 0, 0); tick(); chk_out("fl.busy", 0, 0, 0, 1);
        flush_IN = 1'b1; IF_stall_request = 1'b1;
        drive(4'b0010, 4'b0000, 5, 6, 0, 0); tick(); chk_out("fl.flush", 0, 0, 0, 0);
        flush_IN = 1'b0; IF_stall_request = 1'b0;
                                              tick(); chk_out("fl.after", 1, 1, 6, 0);
        drive(4'b0000, 4'b0000, 0, 0, 0, 0); tick(); chk_out("fl.end", 0, 0, 0, 0);

        // Asynchronous reset mid-BUSY.
        drive(4'b0001, 4'b0001, 7, 0, 0, 0); tick(); chk_out("rs.grant", 1, 0, 7, 1);
        drive(4'b0001, 4'b0000, 7, 0, 0, 0);
        #3 RESET = 1'b1;
        #1 chk_out("rs.async", 0, 0, 0, 0);
        tick(); chk_out("rs.held", 0, 0, 0, 0);
        #3 RESET = 1'b0;
        #1 chk_out("rs.rel", 0, 0, 0, 0);
        tick(); chk_out("rs.first", 1, 0, 7, 0);
        drive(4'b0000, 4'b0000, 0, 0, 0, 0); tick(); chk_out("rs.end", 0, 0, 0, 0);

        // Random traffic; ages sit in a small window above a random base, so
        // "oldest" is simply the smallest offset from that base.
        RESET = 1'b1; #2 RESET = 1'b0;
        rem = 0; mmask = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] base;
            logic [31:0] off [4];
            logic [3:0]  v, md;
            logic        st, fl, ev;
            int          best;
            base = $urandom;
            for (int j = 0; j < 4; j++) off[j] = $urandom_range(0, 15);
            v  = 4'($urandom);
            md = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 29) == 0);
            drive(v, md, base + off[0], base + off[1], base + off[2], base + off[3]);
            IF_stall_request = st;
            flush_IN = fl;
            ev = 1'b0; best = -1;
            if (fl) begin
                rem = 0; mmask = 4'b0;
            end else if (st) begin
                ev = 1'b0;
            end else if (rem > 0) begin
                rem--; mmask = 4'b0;
            end else begin
                for (int j = 0; j < 4; j++)
                    if (v[j] && !mmask[j] && (best < 0 || off[j] < off[best])) best = j;
                mmask = 4'b0;
                if (best >= 0) begin
                    ev = 1'b1;
                    mmask[best] = 1'b1;
                    rem = md[best] ? LAT - 1 : 0;
                end
            end
            tick();
            chk_out("rnd", ev, ev ? best : 0, ev ? base + off[best] : 32'd0, rem > 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
